instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the main control decoder. Accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready handshake and packs them into 32-bit RV instruction words.
- Encoded words are buffered in a small FIFO and streamed out as sequential write transfers (address plus data) into instruction memory.
- Used to load test programs into the CPU's instruction memory from the bench or a boot loader.

Parameters:
- ADDR_W, 8, byte-address width of the memory write port.
- BASE_ADDR, 0, first write address after start_i.
- FIFO_DEPTH, 2, number of buffered encoded words (power of 2, at least 2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse. From IDLE or DONE: address counter := BASE_ADDR, error state cleared, enter RUN.
- finish_i  in  1  pulse in RUN: stop accepting, drain FIFO.
- in_valid_i  in  1  input fields valid.
- in_ready_o  out  1  encoder can accept.
- class_i  in  3  0=LD, 1=ALUI (addi/slti), 2=SD, 3=R, 4=BEQ, 5..7 illegal.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3;  funct7_i  in  7.
- imm_i  in  12  I/S: imm[11:0]; BEQ: offset bits [12:1].
- out_valid_o  out  1  write transfer valid.
- out_ready_i  in  1  memory accepts.
- out_addr_o  out  ADDR_W  byte address (word aligned).
- out_instr_o  out  32  encoded word.
- err_o  out  1  sticky; illegal class seen.
- done_o  out  1  high in DONE.

Behaviour:
- Reset: state IDLE. in_ready_o=0, out_valid_o=0, out_addr_o=BASE_ADDR, out_instr_o=0, err_o=0, done_o=0. FIFO empty.
- States:
  - IDLE: start_i -> RUN.
  - RUN: in_ready_o = !fifo_full && !addr_exhausted. finish_i -> DRAIN.
  - DRAIN: in_ready_o=0. FIFO empty -> DONE (or PAD, see Optional Feature).
  - DONE: done_o=1. start_i -> RUN.
- Input handshake: transfer when in_valid_i && in_ready_o. Encoding is combinational; the word is pushed into the FIFO in the same cycle. Latency from input accept to out_valid_o is 1 cycle.
- Encodings (opcode in bits [6:0]):
  - LD: {imm[11:0], rs1, f3, rd, 0000011}
  - ALUI: {imm[11:0], rs1, f3, rd, 0010011}
  - SD: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  - R: {f7, rs2, rs1, f3, rd, 0110011}
  - BEQ: {imm_i[11], imm_i[9:4], rs2, rs1, f3, imm_i[3:0], imm_i[10], 1100011}
- Illegal class: the input is still accepted, nothing is pushed, and err_o is set. err_o holds until the next start_i or reset.
- Output: FIFO head drives out_instr_o. Transfer when out_valid_o && out_ready_i; the address counter then advances by 4. out_addr_o and out_instr_o stay stable while out_valid_o && !out_ready_i.
- Push and pop in the same cycle with the FIFO full is allowed; occupancy is unchanged.
- Address exhaustion: after the transfer at 2^ADDR_W-4 the counter does not wrap.
  - RUN: in_ready_o is forced low.
  - The FSM moves to DRAIN on its own, then DONE.
- start_i in RUN or DRAIN is ignored. finish_i outside RUN is ignored.
- If start_i and finish_i are asserted together in IDLE, start_i wins and finish_i is ignored.
- Reset asserted mid-operation: immediate return to reset values; FIFO contents are lost.

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- Defined: DRAIN exits to a PAD state instead of DONE. PAD emits 0x00000013 (addi x0,x0,0) on each out_ready_i transfer until the final address (2^ADDR_W-4) is written, then enters DONE. If that address is already written, PAD is skipped.
- Undefined: no PAD state; DRAIN -> DONE; memory past the last written word is untouched.

Decomposition:
- Shared package `instr_pkg`:
  - class codes (CLS_LD..CLS_BEQ)
  - opcode constants (OP_LOAD=0000011, OP_IMM=0010011, OP_STORE=0100011, OP_R=0110011, OP_BRANCH=1100011)
  - NOP_WORD=32'h00000013
  - state encoding
- The decoder shall use the same package opcodes.
- One sub-module: `enc_fifo`, a parameterised synchronous FIFO with full/empty flags. Encoding logic and FSM stay in the top.

Test Plan:
- Reset, start_i, ALUI rd=1 rs1=0 f3=0 imm=5 -> out_instr_o=0x00500093 at out_addr_o=0x00, one cycle after accept.
- R rd=3 rs1=1 rs2=2 f3=0 f7=0, then SD rs1=1 rs2=2 f3=2 imm=8 -> 0x002081B3 @0x00, then 0x0020A423 @0x04.
- BEQ rs1=1 rs2=2 f3=0 imm_i=0xFFC, then LD rd=5 rs1=2 f3=3 imm=16 -> 0xFE208CE3, then 0x01013283.
- out_ready_i held low with 3 inputs offered -> in_ready_o low once 2 are buffered, outputs held stable. Release -> 3 words at consecutive addresses, none lost.
- class_i=6 -> no transfer, err_o=1 and sticky. Next start_i clears it. Reset asserted mid-RUN -> all outputs return to reset values the same cycle.
- ADDR_W=4: write 2 words then finish_i.
  - ENC_NOP_PAD_EN defined: 0x13 written at 0x8 and 0xC, then done_o=1.
  - Undefined: done_o=1 after 2 words.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg: shared class codes, RV opcodes, FSM states and the field-to-word encoder.
package instr_pkg;
    localparam logic [2:0] CLS_LD   = 3'd0;
    localparam logic [2:0] CLS_ALUI = 3'd1;
    localparam logic [2:0] CLS_SD   = 3'd2;
    localparam logic [2:0] CLS_R    = 3'd3;
    localparam logic [2:0] CLS_BEQ  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_PAD, S_DONE} state_t;

    // BEQ imm carries offset bits [12:1], so imm[11] is the sign and imm[10] is offset bit 11
    function automatic logic [31:0] encode(input logic [2:0] cls, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [11:0] imm);
        return cls == CLS_LD   ? {imm, rs1, f3, rd, OP_LOAD} :
               cls == CLS_ALUI ? {imm, rs1, f3, rd, OP_IMM} :
               cls == CLS_SD   ? {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE} :
               cls == CLS_R    ? {f7, rs2, rs1, f3, rd, OP_R} :
                                 {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], OP_BRANCH};
    endfunction
endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO with full/empty flags; push while full is taken only alongside a pop.
module enc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into RV words and streams them as memory writes.
// ENC_NOP_PAD_EN: after draining, fill the remaining memory with NOPs before DONE.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        class_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [11:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [31:0]       out_instr_o,
    output logic              err_o,
    output logic              done_o
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    state_t            state;
    logic [ADDR_W-1:0] addr, paddr;
    logic              exh, pexh, pad;
    logic              legal, acc, push, xfer, pop, full, empty;
    logic [31:0]       word, head;

`ifdef ENC_NOP_PAD_EN
    assign pad = state == S_PAD;
`else
    assign pad = 1'b0;
`endif

    // paddr/pexh reserve an address per pushed word so the FIFO never holds a word with no slot left
    assign legal       = class_i <= CLS_BEQ;
    assign in_ready_o  = state == S_RUN && !full && !pexh;
    assign acc         = in_valid_i && in_ready_o;
    assign push        = acc && legal;
    assign out_valid_o = !empty || pad;
    assign xfer        = out_valid_o && out_ready_i;
    assign pop         = xfer && !empty;
    assign out_addr_o  = addr;
    assign out_instr_o = pad ? NOP_WORD : empty ? 32'h0 : head;
    assign done_o      = state == S_DONE;
    assign word        = encode(class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);

    enc_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_i), .rst_n(rst_i), .push(push), .pop(pop),
        .din(word), .dout(head), .full(full), .empty(empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            addr  <= BASE;
            paddr <= BASE;
            exh   <= 1'b0;
            pexh  <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (xfer) begin
                if (addr == LAST) exh <= 1'b1;
                else addr <= addr + STEP;
            end
            if (push) begin
                if (paddr == LAST) pexh <= 1'b1;
                else paddr <= paddr + STEP;
            end
            if (acc && !legal) err_o <= 1'b1;
            case (state)
                S_IDLE, S_DONE: if (start_i) begin
                    state <= S_RUN;
                    addr  <= BASE;
                    paddr <= BASE;
                    exh   <= 1'b0;
                    pexh  <= 1'b0;
                    err_o <= 1'b0;
                end
                S_RUN:   if (finish_i || exh) state <= S_DRAIN;
                S_DRAIN: if (empty) begin
`ifdef ENC_NOP_PAD_EN
                    state <= exh ? S_DONE : S_PAD;
`else
                    state <= S_DONE;
`endif
                end
                S_PAD:   if (xfer && addr == LAST) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of instr_encoder (ADDR_W=8 and ADDR_W=4 instances).
// Follows ENC_NOP_PAD_EN to pick the expected end-of-memory behaviour.
module tb_instr_encoder;
    import instr_pkg::*;

    logic clk = 1'b0, rst_i = 1'b0, start_i = 1'b0, finish_i = 1'b0;
    logic in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [2:0] class_i = '0, funct3_i = '0;
    logic [4:0] rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [6:0] funct7_i = '0;
    logic [11:0] imm_i = '0;

    logic a_ready, a_valid, a_err, a_done;
    logic [7:0] a_addr;
    logic [31:0] a_instr;
    logic b_ready, b_valid, b_err, b_done;
    logic [3:0] b_addr;
    logic [31:0] b_instr;

    logic sel = 1'b0;
    logic o_ready, o_valid, o_err, o_done;
    logic [7:0] o_addr;
    logic [31:0] o_instr;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) u_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .finish_i(finish_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_ready), .class_i(class_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .imm_i(imm_i), .out_valid_o(a_valid),
        .out_ready_i(out_ready_i), .out_addr_o(a_addr), .out_instr_o(a_instr),
        .err_o(a_err), .done_o(a_done)
    );

    instr_encoder #(.ADDR_W(4)) u_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .finish_i(finish_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_ready), .class_i(class_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .imm_i(imm_i), .out_valid_o(b_valid),
        .out_ready_i(out_ready_i), .out_addr_o(b_addr), .out_instr_o(b_instr),
        .err_o(b_err), .done_o(b_done)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_err   = sel ? b_err : a_err;
    assign o_done  = sel ? b_done : a_done;
    assign o_addr  = sel ? {4'h0, b_addr} : a_addr;
    assign o_instr = sel ? b_instr : a_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] im);
        @(negedge clk);
        class_i = c; rd_i = rd; rs1_i = r1; rs2_i = r2; funct3_i = f3; funct7_i = f7; imm_i = im;
        in_valid_i = 1'b1;
        for (int i = 0; i < 20 && !o_ready; i++) @(negedge clk);
        chk("send_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] ea, input logic [31:0] ew);
        @(negedge clk);
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && !o_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_addr"}, 32'(o_addr), 32'(ea));
        chk({tag, "_instr"}, o_instr, ew);
        @(posedge clk);
        #1 out_ready_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic pulse_finish();
        @(negedge clk) finish_i = 1'b1;
        @(negedge clk) finish_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !o_done; i++) @(negedge clk);
        chk(tag, 32'(o_done), 32'd1);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(o_ready), 32'd0);
        chk("rst_out_valid", 32'(o_valid), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        rst_i = 1'b1;

        pulse_start();
        chk("run_in_ready", 32'(o_ready), 32'd1);
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5);
        @(negedge clk);
        chk("alui_lat_valid", 32'(o_valid), 32'd1);
        chk("alui_lat_instr", o_instr, 32'h0050_0093);
        recv("alui", 8'h00, 32'h0050_0093);
        pulse_finish();
        wait_done("first_done");

        pulse_start();
        chk("restart_done", 32'(o_done), 32'd0);
        send(CLS_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
        send(CLS_SD, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd8);
        recv("r", 8'h00, 32'h0020_81B3);
        recv("sd", 8'h04, 32'h0020_A423);
        send(CLS_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'hFFC);
        send(CLS_LD, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 12'd16);
        recv("beq", 8'h08, 32'hFE20_8CE3);
        recv("ld", 8'h0C, 32'h0101_3283);

        // backpressure: two buffered words fill the FIFO
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd1);
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd2);
        @(negedge clk);
        imm_i = 12'd3;
        in_valid_i = 1'b1;
        chk("full_in_ready", 32'(o_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 32'(o_ready), 32'd0);
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_addr", 32'(o_addr), 32'h10);
        chk("stall_instr", o_instr, 32'h0010_0093);
        in_valid_i = 1'b0;
        recv("bp1", 8'h10, 32'h0010_0093);
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd3);
        recv("bp2", 8'h14, 32'h0020_0093);
        recv("bp3", 8'h18, 32'h0030_0093);

        // illegal class is swallowed and flagged
        send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5);
        @(negedge clk);
        chk("ill_err", 32'(o_err), 32'd1);
        chk("ill_no_push", 32'(o_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("ill_sticky", 32'(o_err), 32'd1);
        chk("ill_addr", 32'(o_addr), 32'h1C);
        pulse_finish();
        wait_done("ill_done");
        chk("ill_sticky_done", 32'(o_err), 32'd1);
        pulse_start();
        chk("start_clr_err", 32'(o_err), 32'd0);
        chk("start_addr", 32'(o_addr), 32'd0);

        // asynchronous reset mid-RUN with a word buffered
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5);
        @(negedge clk);
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd0);
        chk("mid_rst_instr", o_instr, 32'd0);
        chk("mid_rst_addr", 32'(o_addr), 32'd0);
        @(negedge clk) rst_i = 1'b1;

        // ADDR_W=4: two words, then finish
        sel = 1'b1;
        @(negedge clk) rst_i = 1'b0;
        @(negedge clk) rst_i = 1'b1;
        pulse_start();
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd1);
        recv("s4w0", 8'h0, 32'h0010_0093);
        send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd2);
        recv("s4w1", 8'h4, 32'h0020_0093);
        pulse_finish();
`ifdef ENC_NOP_PAD_EN
        recv("pad8", 8'h8, NOP_WORD);
        recv("padC", 8'hC, NOP_WORD);
        wait_done("pad_done");
`else
        wait_done("nopad_done");
        chk("nopad_valid", 32'(o_valid), 32'd0);
        chk("nopad_addr", 32'(o_addr), 32'h8);
`endif

        // ADDR_W=4: fill every address, FSM finishes on its own
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send(CLS_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'(k + 1));
            recv("fill", 8'(4 * k), 32'(((k + 1) << 20) | 32'h93));
        end
        @(negedge clk);
        chk("exh_in_ready", 32'(o_ready), 32'd0);
        wait_done("exh_done");
        chk("exh_addr", 32'(o_addr), 32'hC);
        chk("exh_valid", 32'(o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
